// File: rtl/lipsi_core_param.sv
// Parametrised Lipsi accumulator processor: multi-cycle FSM, carry flag, shifts, indirect
// load/store, halt, run/stall control and a host port for loading the instruction memory.
module lipsi_core_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 16,
    localparam int unsigned PC_W      = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [7:0]        prog_data,
    output logic [DATA_W-1:0] A,
    output logic [PC_W-1:0]   pc,
    output logic              carry,
    output logic              halted
);

    localparam int unsigned DM_W = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {StExec, StOpnd, StInd, StHalt} state_e;

    logic [7:0]        imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    state_e            state_q;
    logic [DATA_W-1:0] a_q;
    logic [PC_W-1:0]   pc_q;
    logic              carry_q;
    logic [DM_W-1:0]   ptr_q;
    // op_q[3] selects the second flavour (branch / indirect store); op_q[2:0] is f or cc.
    logic [3:0]        op_q;

    logic [7:0]        op_byte;
    logic [PC_W-1:0]   pc_inc;
    logic [DM_W-1:0]   dir_idx;
    logic [DATA_W-1:0] dmem_dir;

    logic [2:0]        alu_f;
    logic [DATA_W-1:0] alu_x;
    logic              alu_cin;
    logic [DATA_W:0]   alu_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    logic [DATA_W-1:0] sh_res;
    logic              sh_c;
    logic              br_taken;

    // Host writes land at the edge, so a fetch in the same cycle still sees the old byte.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    assign op_byte  = imem[pc_q];
    assign pc_inc   = pc_q + PC_W'(1);
    assign dir_idx  = DM_W'(op_byte[3:0]);
    assign dmem_dir = dmem[dir_idx];

    // In OPND the byte at pc is the immediate; in EXEC the operand is a direct DMEM word.
    always_comb begin
        alu_f = op_byte[6:4];
        alu_x = dmem_dir;
        if (state_q == StOpnd) begin
            alu_f = op_q[2:0];
            alu_x = DATA_W'(op_byte);
        end
    end

    assign alu_cin = alu_f[1] & carry_q;

    always_comb begin
        alu_ext = '0;
        case (alu_f)
            3'd0, 3'd2: alu_ext = {1'b0, a_q} + {1'b0, alu_x} + {{DATA_W{1'b0}}, alu_cin};
            3'd1, 3'd3: alu_ext = {1'b0, a_q} - {1'b0, alu_x} - {{DATA_W{1'b0}}, alu_cin};
            3'd4:       alu_ext = {carry_q, a_q & alu_x};
            3'd5:       alu_ext = {carry_q, a_q | alu_x};
            3'd6:       alu_ext = {carry_q, a_q ^ alu_x};
            default:    alu_ext = {carry_q, alu_x};
        endcase
    end

    assign alu_res = alu_ext[DATA_W-1:0];
    assign alu_c   = alu_ext[DATA_W];

    always_comb begin
        case (op_byte[1:0])
            2'd0:    {sh_c, sh_res} = {a_q, 1'b0};
            2'd1:    {sh_res, sh_c} = {1'b0, a_q};
            2'd2:    {sh_c, sh_res} = {a_q, carry_q};
            default: {sh_res, sh_c} = {carry_q, a_q};
        endcase
    end

    always_comb begin
        case (op_q[1:0])
            2'd0:    br_taken = 1'b1;
            2'd1:    br_taken = carry_q;
            2'd2:    br_taken = (a_q == '0);
            default: br_taken = (a_q != '0);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StExec;
            a_q     <= '0;
            pc_q    <= '0;
            carry_q <= 1'b0;
            ptr_q   <= '0;
            op_q    <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem[i] <= '0;
            end
        end else if (run) begin
            case (state_q)
                StExec: begin
                    pc_q <= pc_inc;
                    if (!op_byte[7]) begin
                        a_q     <= alu_res;
                        carry_q <= alu_c;
                    end else if (op_byte[6:4] == 3'b000) begin
                        dmem[dir_idx] <= a_q;
                    end else if (op_byte[6:5] == 2'b01) begin
                        ptr_q   <= dmem_dir[DM_W-1:0];
                        op_q    <= {op_byte[4], 3'b000};
                        pc_q    <= pc_q;
                        state_q <= StInd;
                    end else if ((op_byte[6:3] == 4'b1000) || (op_byte[6:2] == 5'b10100)) begin
                        op_q    <= {op_byte[4], op_byte[2:0]};
                        state_q <= StOpnd;
                    end else if (op_byte[6:2] == 5'b11000) begin
                        a_q     <= sh_res;
                        carry_q <= sh_c;
                    end else if (op_byte == 8'hFF) begin
                        pc_q    <= pc_q;
                        state_q <= StHalt;
                    end
                end
                StOpnd: begin
                    if (!op_q[3]) begin
                        a_q     <= alu_res;
                        carry_q <= alu_c;
                        pc_q    <= pc_inc;
                    end else begin
                        pc_q    <= br_taken ? op_byte[PC_W-1:0] : pc_inc;
                    end
                    state_q <= StExec;
                end
                StInd: begin
                    if (!op_q[3]) begin
                        a_q <= dmem[ptr_q];
                    end else begin
                        dmem[ptr_q] <= a_q;
                    end
                    pc_q    <= pc_inc;
                    state_q <= StExec;
                end
                default: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end

    assign A      = a_q;
    assign pc     = pc_q;
    assign carry  = carry_q;
    assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_lipsi_core_param.sv
// Bench for lipsi_core_param: directed program table, multi-cycle corner sequences and
// random programs checked against an instruction-level reference model.
module tb_lipsi_core_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        run8, run16, we8, we16;
    logic [7:0]  prog_addr, prog_data;
    logic [7:0]  a8, pc8, pc16;
    logic [15:0] a16;
    logic        c8, h8, c16, h16;

    always #5 clk = ~clk;

    lipsi_core_param dut8 (
        .clk(clk), .reset(reset), .run(run8), .prog_we(we8), .prog_addr(prog_addr),
        .prog_data(prog_data), .A(a8), .pc(pc8), .carry(c8), .halted(h8)
    );

    lipsi_core_param #(.DATA_W(16), .IMEM_DEPTH(256), .DMEM_DEPTH(32)) dut16 (
        .clk(clk), .reset(reset), .run(run16), .prog_we(we16), .prog_addr(prog_addr),
        .prog_data(prog_data), .A(a16), .pc(pc16), .carry(c16), .halted(h16)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit           wide;
        logic [127:0] prog;
        logic [15:0]  a;
        logic [7:0]   pc;
        logic         c;
    } vec_t;

    vec_t vecs[16];

    // Reference model state (8-bit core, 16-word data memory).
    int         ma, mpc, mc;
    bit         mh;
    int         mdm[16];
    logic [7:0] mem[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cur_a(input bit wide);
        return wide ? a16 : {8'h00, a8};
    endfunction
    function automatic logic [7:0] cur_pc(input bit wide);
        return wide ? pc16 : pc8;
    endfunction
    function automatic logic cur_c(input bit wide);
        return wide ? c16 : c8;
    endfunction
    function automatic logic cur_h(input bit wide);
        return wide ? h16 : h8;
    endfunction

    task automatic write_byte(input bit wide, input logic [7:0] addr, input logic [7:0] data);
        prog_addr = addr;
        prog_data = data;
        we8 = !wide;
        we16 = wide;
        tick();
        we8 = 1'b0;
        we16 = 1'b0;
    endtask

    task automatic load_prog(input bit wide, input logic [127:0] prog);
        reset = 1'b0;
        run8 = 1'b0;
        run16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            write_byte(wide, 8'(i), prog[127-8*i -: 8]);
        end
    endtask

    task automatic start(input bit wide);
        reset = 1'b1;
        run8 = !wide;
        run16 = wide;
    endtask

    task automatic run_to_halt(input bit wide, input string name);
        for (int n = 0; n < 300; n++) begin
            if (cur_h(wide)) break;
            tick();
        end
        check({name, " halted"}, 32'(cur_h(wide)), 32'd1);
    endtask

    task automatic model_alu(input int f, input int x);
        int t;
        case (f)
            0: begin t = ma + x;      mc = (t > 255) ? 1 : 0; end
            1: begin t = ma - x;      mc = (t < 0) ? 1 : 0;   end
            2: begin t = ma + x + mc; mc = (t > 255) ? 1 : 0; end
            3: begin t = ma - x - mc; mc = (t < 0) ? 1 : 0;   end
            4: t = ma & x;
            5: t = ma | x;
            6: t = ma ^ x;
            default: t = x;
        endcase
        ma = t & 255;
    endtask

    task automatic model_step(output int cyc);
        int op, nxt, cond, oc;
        op = int'(mem[mpc]);
        nxt = int'(mem[(mpc + 1) % 256]);
        cyc = 1;
        if (mh) begin
            cyc = 1;
        end else if (op == 255) begin
            mh = 1'b1;
        end else if (op < 128) begin
            model_alu(op / 16, mdm[op % 16]);
            mpc = (mpc + 1) % 256;
        end else if (op < 144) begin
            mdm[op % 16] = ma;
            mpc = (mpc + 1) % 256;
        end else if (op >= 160 && op < 176) begin
            ma = mdm[mdm[op % 16] % 16];
            mpc = (mpc + 1) % 256;
            cyc = 2;
        end else if (op >= 176 && op < 192) begin
            mdm[mdm[op % 16] % 16] = ma;
            mpc = (mpc + 1) % 256;
            cyc = 2;
        end else if (op >= 192 && op < 200) begin
            model_alu(op - 192, nxt);
            mpc = (mpc + 2) % 256;
            cyc = 2;
        end else if (op >= 208 && op < 212) begin
            case (op - 208)
                0: cond = 1;
                1: cond = mc;
                2: cond = (ma == 0) ? 1 : 0;
                default: cond = (ma != 0) ? 1 : 0;
            endcase
            mpc = (cond != 0) ? nxt : (mpc + 2) % 256;
            cyc = 2;
        end else if (op >= 224 && op < 228) begin
            oc = mc;
            case (op - 224)
                0: begin mc = ma / 128; ma = (ma * 2) % 256;      end
                1: begin mc = ma % 2;   ma = ma / 2;              end
                2: begin mc = ma / 128; ma = (ma * 2 + oc) % 256; end
                default: begin mc = ma % 2; ma = ma / 2 + oc * 128; end
            endcase
            mpc = (mpc + 1) % 256;
        end else begin
            mpc = (mpc + 1) % 256;
        end
    endtask

    function automatic logic [7:0] rand_op();
        int k;
        k = $urandom_range(0, 19);
        if (k < 5)       return {1'b0, 3'($urandom), 4'($urandom)};
        else if (k < 7)  return {4'h8, 4'($urandom)};
        else if (k < 9)  return {3'b101, 1'($urandom), 4'($urandom)};
        else if (k < 12) return {5'b11000, 3'($urandom)};
        else if (k < 14) return {6'b110100, 2'($urandom)};
        else if (k < 17) return {6'b111000, 2'($urandom)};
        else if (k == 17 && $urandom_range(0, 3) == 0) return 8'hFF;
        else             return 8'($urandom);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] seen[$];
        logic [7:0] prev;
        int         cyc;

        reset = 1'b0;
        run8 = 1'b0;
        run16 = 1'b0;
        we8 = 1'b0;
        we16 = 1'b0;
        prog_addr = '0;
        prog_data = '0;

        vecs[0]  = '{1'b0, {56'hC705C101D302FF, 72'h0}, 16'h0000, 8'd6, 1'b0};
        vecs[1]  = '{1'b0, {56'hC7FFC001C200FF, 72'h0}, 16'h0001, 8'd6, 1'b0};
        vecs[2]  = '{1'b0, {40'hC700C101FF, 88'h0}, 16'h00FF, 8'd4, 1'b1};
        vecs[3]  = '{1'b0, {40'hC781E0E3FF, 88'h0}, 16'h0081, 8'd4, 1'b0};
        vecs[4]  = '{1'b1, {80'hC71480C7ABB0C700A0FF, 48'h0}, 16'h00AB, 8'd9, 1'b0};
        vecs[5]  = '{1'b1, {88'hC7FFE0E0E0E0E0E0E0E0FF, 40'h0}, 16'hFF00, 8'd10, 1'b0};
        vecs[6]  = '{1'b0, {32'hC703E1FF, 96'h0}, 16'h0001, 8'd3, 1'b1};
        vecs[7]  = '{1'b0, {40'hC780E2E2FF, 88'h0}, 16'h0001, 8'd4, 1'b0};
        vecs[8]  = '{1'b0, {72'hC7FFC001D108C755FF, 56'h0}, 16'h0000, 8'd8, 1'b1};
        vecs[9]  = '{1'b0, {56'hC703D206C510FF, 72'h0}, 16'h0013, 8'd6, 1'b0};
        vecs[10] = '{1'b0, {56'hC7F0C6FFC43CFF, 72'h0}, 16'h000C, 8'd6, 1'b0};
        vecs[11] = '{1'b0, {56'hC70781C70501FF, 72'h0}, 16'h000C, 8'd6, 1'b0};
        vecs[12] = '{1'b0, {56'hC700C101C300FF, 72'h0}, 16'h00FE, 8'd6, 1'b0};
        vecs[13] = '{1'b1, {40'hC7FFC001FF, 88'h0}, 16'h0100, 8'd4, 1'b0};
        vecs[14] = '{1'b1, {40'hC700C101FF, 88'h0}, 16'hFFFF, 8'd4, 1'b1};
        vecs[15] = '{1'b0, {48'hC70590C8E4FF, 80'h0}, 16'h0005, 8'd5, 1'b0};

        for (int i = 0; i < 16; i++) begin
            load_prog(vecs[i].wide, vecs[i].prog);
            check($sformatf("v%0d reset A", i), 32'(cur_a(vecs[i].wide)), 32'd0);
            check($sformatf("v%0d reset pc", i), 32'(cur_pc(vecs[i].wide)), 32'd0);
            check($sformatf("v%0d reset halted", i), 32'(cur_h(vecs[i].wide)), 32'd0);
            start(vecs[i].wide);
            run_to_halt(vecs[i].wide, $sformatf("v%0d", i));
            check($sformatf("v%0d A", i), 32'(cur_a(vecs[i].wide)), 32'(vecs[i].a));
            check($sformatf("v%0d pc", i), 32'(cur_pc(vecs[i].wide)), 32'(vecs[i].pc));
            check($sformatf("v%0d carry", i), 32'(cur_c(vecs[i].wide)), 32'(vecs[i].c));
        end

        // Countdown: accumulator trajectory, then frozen in HALT.
        load_prog(1'b0, {56'hC705C101D302FF, 72'h0});
        start(1'b0);
        prev = 8'h00;
        for (int n = 0; n < 300; n++) begin
            if (h8) break;
            tick();
            if (a8 != prev) seen.push_back(a8);
            prev = a8;
        end
        check("countdown steps", 32'(seen.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("countdown value", (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD, 32'(5 - i));
        end
        for (int n = 0; n < 10; n++) begin
            tick();
            check("halt A", 32'(a8), 32'd0);
            check("halt pc", 32'(pc8), 32'd6);
            check("halt carry", 32'(c8), 32'd0);
            check("halt flag", 32'(h8), 32'd1);
        end

        // Carry chain intermediate values.
        load_prog(1'b0, {56'hC7FFC001C200FF, 72'h0});
        start(1'b0);
        repeat (4) tick();
        check("add A", 32'(a8), 32'h00);
        check("add carry", 32'(c8), 32'd1);
        repeat (2) tick();
        check("adc A", 32'(a8), 32'h01);
        check("adc carry", 32'(c8), 32'd0);

        // Shift intermediate values.
        load_prog(1'b0, {40'hC781E0E3FF, 88'h0});
        start(1'b0);
        repeat (3) tick();
        check("shl A", 32'(a8), 32'h02);
        check("shl carry", 32'(c8), 32'd1);
        tick();
        check("ror A", 32'(a8), 32'h81);
        check("ror carry", 32'(c8), 32'd0);

        // Stall for five cycles while the operand fetch is pending.
        load_prog(1'b0, {56'hC705C101D302FF, 72'h0});
        start(1'b0);
        tick();
        run8 = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("stall pc", 32'(pc8), 32'd1);
            check("stall A", 32'(a8), 32'd0);
        end
        run8 = 1'b1;
        tick();
        check("resume A", 32'(a8), 32'd5);
        check("resume pc", 32'(pc8), 32'd2);
        run_to_halt(1'b0, "resume");
        check("resume final A", 32'(a8), 32'd0);
        check("resume final pc", 32'(pc8), 32'd6);

        // Asynchronous reset in the middle of a two-byte op.
        load_prog(1'b0, {56'hC7FFC001C200FF, 72'h0});
        start(1'b0);
        repeat (5) tick();
        check("pre-reset carry", 32'(c8), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset A", 32'(a8), 32'd0);
        check("async reset pc", 32'(pc8), 32'd0);
        check("async reset carry", 32'(c8), 32'd0);
        #1 reset = 1'b1;
        run_to_halt(1'b0, "restart");
        check("restart A", 32'(a8), 32'h01);
        check("restart pc", 32'(pc8), 32'd6);
        check("restart carry", 32'(c8), 32'd0);

        // Two-byte op at the last address fetches its operand from address 0.
        load_prog(1'b0, {16'hD0FF, 112'h0});
        write_byte(1'b0, 8'hFF, 8'hC7);
        start(1'b0);
        run_to_halt(1'b0, "wrap");
        check("wrap A", 32'(a8), 32'hD0);
        check("wrap pc", 32'(pc8), 32'd1);

        // A host write to the byte being fetched is not seen by that fetch.
        load_prog(1'b0, {24'hC711FF, 104'h0});
        start(1'b0);
        prog_addr = 8'h00;
        prog_data = 8'hFF;
        we8 = 1'b1;
        tick();
        we8 = 1'b0;
        check("same-cycle write halted", 32'(h8), 32'd0);
        check("same-cycle write pc", 32'(pc8), 32'd1);
        run_to_halt(1'b0, "same-cycle write");
        check("same-cycle write A", 32'(a8), 32'h11);
        check("same-cycle write final pc", 32'(pc8), 32'd2);

        // Random programs with random stalls against the reference model.
        for (int p = 0; p < 6; p++) begin
            reset = 1'b0;
            run8 = 1'b0;
            for (int i = 0; i < 256; i++) begin
                mem[i] = rand_op();
                write_byte(1'b0, 8'(i), mem[i]);
            end
            ma = 0;
            mpc = 0;
            mc = 0;
            mh = 1'b0;
            for (int i = 0; i < 16; i++) mdm[i] = 0;
            start(1'b0);
            for (int k = 0; k < 100; k++) begin
                model_step(cyc);
                for (int e = 0; e < cyc; e++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        run8 = 1'b0;
                        tick();
                        run8 = 1'b1;
                    end
                    tick();
                end
                check("rand A", 32'(a8), 32'(ma));
                check("rand pc", 32'(pc8), 32'(mpc));
                check("rand carry", 32'(c8), 32'(mc));
                check("rand halted", 32'(h8), 32'(mh));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
